// File: rtl/ifetch_pq.sv
// Instruction prefetch queue: issues word fetches over a req/ack handshake,
// buffers returned words in a fall-through FIFO and flushes on core redirects.
module ifetch_pq #(
  parameter int                ADDR_W = 16,
  parameter int                DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RST_PC = 16'h0000
) (
  input  logic                       CLK,
  input  logic                       RST_F,
  input  logic                       fetch_en,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_data,
  output logic [31:0]                ir,
  output logic [ADDR_W-1:0]          ir_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam int                PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  cnt_after;
  logic              push, pop, flush;
  entry_t            fifo_mem [DEPTH];

  assign ir_valid = (count_q != '0);
  // A redirect cancels any pop in its cycle; popping an empty queue is a no-op.
  assign pop      = ir_valid & ir_ready & ~redirect;
  assign cnt_after = count_q + CNT_W'(1) - CNT_W'(pop);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    // NOTE: blocking assignments here model combinational wires; the
    // registers below take these values with non-blocking assignments.
    if (redirect) begin
      flush = 1'b1;
      fpc_d = redirect_addr;
    end
    unique case (state_q)
      S_IDLE: begin
        if (fetch_en && (count_q < FULL) && !redirect) begin
          req_addr_d = fpc_q;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          // The word returning this cycle (if any) belongs to the old path.
          state_d = mem_ack ? S_IDLE : S_DISCARD;
        end else if (mem_ack) begin
          push  = 1'b1;
          fpc_d = fpc_q + ADDR_W'(1);
          if (fetch_en && (cnt_after < FULL)) begin
            req_addr_d = fpc_q + ADDR_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_q    <= S_IDLE;
      fpc_q      <= RST_PC;
      req_addr_q <= RST_PC;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage has no reset; count gates visibility, so stale entries are
  // never observable and the array maps onto plain registers or RAM.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: req_addr_q, data: mem_data};
  end

  assign mem_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
  assign mem_addr = req_addr_q;
  assign ir       = ir_valid ? fifo_mem[rd_ptr_q].data : '0;
  assign ir_pc    = ir_valid ? fifo_mem[rd_ptr_q].addr : '0;
  assign count    = count_q;

endmodule

// File: tb/tb_ifetch_pq.sv
// Directed bench for ifetch_pq: a latency-configurable memory model plus
// monitors logging accepted fetches and consumed instructions.
module tb_ifetch_pq;

  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RST_F = 1'b0;
  logic          fetch_en = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_data;
  logic [31:0]   ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic [2:0]    count;

  int lat = 1;
  int lat_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] ack_q [$];
  logic [AW-1:0] pc_q  [$];
  logic [31:0]   dat_q [$];

  ifetch_pq #(.ADDR_W(AW), .DEPTH(4), .RST_PC(16'h0000)) dut (
    .CLK          (CLK),
    .RST_F        (RST_F),
    .fetch_en     (fetch_en),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .count        (count)
  );

  always #5 CLK = ~CLK;

  // Memory answers lat cycles after a request appears (lat=0: same cycle).
  assign mem_ack  = mem_req && (lat_cnt == lat);
  assign mem_data = mem_ack ? (32'hA000_0000 + {16'h0000, mem_addr}) : 32'h0;

  always @(posedge CLK) begin
    if (!mem_req || mem_ack) lat_cnt <= 0;
    else                     lat_cnt <= lat_cnt + 1;
  end

  always @(negedge CLK) begin
    if (mem_req && mem_ack) ack_q.push_back(mem_addr);
    if (ir_valid && ir_ready && !redirect) begin
      pc_q.push_back(ir_pc);
      dat_q.push_back(ir);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_F    = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    RST_F = 1'b1;
    ack_q.delete();
    pc_q.delete();
    dat_q.delete();
  endtask

  task automatic check_consumed(input string tag, input int i, input logic [AW-1:0] exp_pc);
    if (i < pc_q.size()) begin
      check({tag, "_pc"}, 64'(pc_q[i]), 64'(exp_pc));
      check({tag, "_data"}, 64'(dat_q[i]), 64'(32'hA000_0000 + {16'h0000, exp_pc}));
    end else begin
      check({tag, "_missing"}, 64'(pc_q.size()), 64'(i + 1));
    end
  endtask

  task automatic check_acked(input string tag, input int i, input logic [AW-1:0] exp_addr);
    if (i < ack_q.size()) check(tag, 64'(ack_q[i]), 64'(exp_addr));
    else                  check({tag, "_missing"}, 64'(ack_q.size()), 64'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // ---- reset state and streaming with 1-cycle memory ----
    lat = 1; fetch_en = 1'b1; ir_ready = 1'b1;
    #3;
    check("rst_mem_req",  64'(mem_req),  64'd0);
    check("rst_ir_valid", 64'(ir_valid), 64'd0);
    check("rst_ir",       64'(ir),       64'd0);
    check("rst_ir_pc",    64'(ir_pc),    64'd0);
    check("rst_count",    64'(count),    64'd0);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (mem_ack) found = 1'b1;
    end
    check("t1_ack_seen", 64'(found), 64'd1);
    check("t1_first_addr", 64'(mem_addr), 64'h0000);
    check("t1_valid_before", 64'(ir_valid), 64'd0);
    tick();
    check("t1_valid_after", 64'(ir_valid), 64'd1);
    check("t1_ir_pc0", 64'(ir_pc), 64'h0000);
    check("t1_ir0", 64'(ir), 64'hA000_0000);
    repeat (20) tick();
    for (int i = 0; i < 6; i++) check_consumed($sformatf("t1_seq%0d", i), i, AW'(i));

    // ---- fill with zero-latency memory and core stalled ----
    lat = 0; ir_ready = 1'b0; fetch_en = 1'b1;
    do_reset();
    repeat (10) tick();
    check("t2_req_count", 64'(ack_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_acked($sformatf("t2_addr%0d", i), i, AW'(i));
    check("t2_full", 64'(count), 64'd4);
    check("t2_req_idle", 64'(mem_req), 64'd0);
    check("t2_head_pc", 64'(ir_pc), 64'h0000);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("t2_after_pop_count", 64'(count), 64'd3);
    check("t2_after_pop_pc", 64'(ir_pc), 64'h0001);
    check("t2_popped_n", 64'(pc_q.size()), 64'd1);
    check_consumed("t2_popped", 0, 16'h0000);
    repeat (4) tick();
    check("t2_refill_n", 64'(ack_q.size()), 64'd5);
    check_acked("t2_refill_addr", 4, 16'h0004);
    check("t2_refill_count", 64'(count), 64'd4);

    // ---- redirect while a slow request is outstanding ----
    lat = 3; ir_ready = 1'b1; fetch_en = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_addr = 16'h0005;
    tick();
    redirect = 1'b0; fetch_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (mem_req && mem_addr == 16'h0005) found = 1'b1;
    end
    check("t3_req5_seen", 64'(found), 64'd1);
    tick();
    redirect = 1'b1; redirect_addr = 16'h0100;
    tick();
    redirect = 1'b0;
    check("t3_discard_req", 64'(mem_req), 64'd1);
    check("t3_discard_addr", 64'(mem_addr), 64'h0005);
    check("t3_discard_count", 64'(count), 64'd0);
    repeat (30) tick();
    check_acked("t3_stale_ack", 0, 16'h0005);
    check_acked("t3_next_req", 1, 16'h0100);
    check_consumed("t3_first_ir", 0, 16'h0100);

    // ---- redirect coincident with ack and pop at count=2 ----
    lat = 0; ir_ready = 1'b0; fetch_en = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (count == 3'd2) found = 1'b1;
    end
    check("t4_count2_seen", 64'(found), 64'd1);
    check("t4_ack_now", 64'(mem_ack), 64'd1);
    redirect = 1'b1; redirect_addr = 16'h0040; ir_ready = 1'b1;
    tick();
    redirect = 1'b0; ir_ready = 1'b0;
    check("t4_count", 64'(count), 64'd0);
    check("t4_valid", 64'(ir_valid), 64'd0);
    check("t4_ir", 64'(ir), 64'd0);
    check("t4_no_pop", 64'(pc_q.size()), 64'd0);
    tick();
    check("t4_req", 64'(mem_req), 64'd1);
    check("t4_addr", 64'(mem_addr), 64'h0040);

    // ---- redirect to the top of the address space ----
    lat = 1; ir_ready = 1'b1; fetch_en = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    tick();
    redirect = 1'b0; fetch_en = 1'b1;
    repeat (12) tick();
    check_consumed("t5_top", 0, 16'hFFFF);
    check_consumed("t5_wrap", 1, 16'h0000);

    // ---- asynchronous reset in the middle of a request ----
    lat = 3; ir_ready = 1'b0; fetch_en = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (count == 3'd2 && mem_req) found = 1'b1;
    end
    check("t6_mid_req_seen", 64'(found), 64'd1);
    #2;
    RST_F = 1'b0;
    #1;
    check("t6_req_drop", 64'(mem_req), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_ir", 64'(ir), 64'd0);
    check("t6_valid", 64'(ir_valid), 64'd0);
    tick();
    tick();
    RST_F = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (mem_req) found = 1'b1;
    end
    check("t6_req_after", 64'(found), 64'd1);
    check("t6_addr_rst_pc", 64'(mem_addr), 64'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_pq.md
Name: ifetch_pq

Overview:
- Instruction prefetch queue sitting directly upstream of the sisc core.
- Fetches 32-bit instruction words from a multi-cycle instruction memory over a req/ack handshake and buffers them in a small FIFO.
- Presents the head word as the core's IR with a valid/ready handshake.
- Flushes and re-fetches from a new address when the core redirects on a taken branch.

Parameters:
- ADDR_W, 16, width of the fetch address and PC (word-addressed).
- DEPTH, 4, FIFO entries (power of two, >= 2).
- RST_PC, 16'h0000, first fetch address after reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_F  input  1  reset, asynchronous, active-low.
- fetch_en  input  1  permits issue of new memory requests.
- mem_req  output  1  request to instruction memory.
- mem_addr  output  ADDR_W  request address; held stable while mem_req=1 until ack.
- mem_ack  input  1  memory response; mem_data valid in the same cycle.
- mem_data  input  32  returned instruction word.
- ir  output  32  head instruction; 32'h0 when ir_valid=0.
- ir_pc  output  ADDR_W  address of the head instruction; 0 when ir_valid=0.
- ir_valid  output  1  FIFO non-empty.
- ir_ready  input  1  core consumes the head when ir_valid & ir_ready.
- redirect  input  1  taken branch: flush and refetch.
- redirect_addr  input  ADDR_W  new fetch address.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Registers:
  - fpc: next fetch address.
  - req_addr: drives mem_addr.
  - FIFO: DEPTH x {ADDR_W, 32}, with rd/wr pointers and count.
  - FSM: IDLE, REQ, DISCARD.
- Reset (async, RST_F=0):
  - fpc=RST_PC, req_addr=RST_PC, state=IDLE.
  - count=0, pointers=0.
  - Outputs: mem_req=0, ir_valid=0, ir=0, ir_pc=0.
  - An outstanding memory request is abandoned.
- mem_req=1 exactly in REQ and DISCARD; mem_addr=req_addr at all times.
- At most one request outstanding.
- IDLE:
  - If fetch_en & count<DEPTH & !redirect: req_addr<=fpc, go to REQ.
  - Otherwise stay in IDLE.
- REQ without ack:
  - Hold req_addr.
  - If redirect: flush FIFO, fpc<=redirect_addr, go to DISCARD.
- REQ with ack and no redirect:
  - Push {req_addr, mem_data}; fpc<=fpc+1, wrapping all-ones to 0.
  - If fetch_en & (count after this cycle's push/pop)<DEPTH: stay in REQ with req_addr<=fpc+1 (back-to-back, 1 word/cycle peak).
  - Otherwise go to IDLE.
- REQ with ack and redirect in the same cycle:
  - Drop mem_data; flush; fpc<=redirect_addr; go to IDLE.
- DISCARD (waits out a stale request):
  - Keep mem_req=1 with the old req_addr.
  - On mem_ack: drop data, go to IDLE.
  - A further redirect only updates fpc.
- Space guarantee: issue needs count<DEPTH and pops only lower count, so an ack never meets a full FIFO.
- FIFO is first-word fall-through.
  - Ack at cycle N gives ir_valid=1 and ir=mem_data from cycle N+1.
  - Pop: rd pointer advances on ir_valid & ir_ready.
  - Simultaneous push and pop: count unchanged.
  - Pop while empty is ignored.
- Redirect priority:
  - Redirect overrides pop and push in its cycle.
  - count=0 and ir_valid=0 the next cycle.
- fetch_en=0 blocks new issue only; an outstanding REQ completes and its word is pushed.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset, fetch_en=1, memory acks one cycle after each req with data=0xA0000000+addr, ir_ready=1:
  - First request to addr 0x0000.
  - ir_valid rises the cycle after the first ack.
  - Core sees ir_pc 0,1,2,… with matching data.
- ir_ready=0, zero-latency ack memory:
  - Exactly 4 requests (addr 0–3), count=4, mem_req stays 0.
  - Raising ir_ready for 1 cycle pops addr 0 and a request for addr 4 issues.
- Memory acks 3 cycles late; assert redirect (addr 0x0100) one cycle after a request to 0x0005 issues:
  - Ack data for 0x0005 is dropped; mem_addr holds 0x0005 until ack.
  - Next request is 0x0100; first ir_pc=0x0100.
- Redirect coincident with ack and with ir_ready while count=2:
  - Next cycle count=0, ir_valid=0.
  - Next request addr=redirect_addr.
- Redirect to 0xFFFF:
  - Fetches 0xFFFF then wraps to 0x0000.
- Assert RST_F=0 mid-REQ:
  - mem_req drops immediately, count=0, ir=0.
  - After release, first mem_addr=RST_PC.
